// File: rtl/mem_access_pkg.sv
// Shared types and constants for the byte-serial data-memory access unit.
package mem_access_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int WORD_BEATS = 4;
   localparam int BYTE_BEATS = 1;
   localparam int BEAT_W     = 2;

   // Lane n holds word bits [8n+7:8n]; the first word beat carries the top lane.
   localparam logic [1:0] LANE_LSB = 2'd0;
   localparam logic [1:0] LANE_MSB = 2'd3;

   function automatic logic [1:0] beat_to_lane(input logic size, input logic [1:0] beat);
      return size ? (LANE_MSB - beat) : LANE_LSB;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Big-endian lane steering: selects the store byte for a beat and merges a load byte into the word.
module mem_byte_lane
   import mem_access_pkg::*;
(
   input  logic        i_size,
   input  logic [1:0]  i_beat,
   input  logic [31:0] i_wdata,
   input  logic [7:0]  i_rbyte,
   input  logic [31:0] i_rword,
   output logic [7:0]  o_wbyte,
   output logic [31:0] o_rword
);

   logic [1:0] w_lane;

   assign w_lane = beat_to_lane(i_size, i_beat);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      o_rword                        = i_rword;
      o_rword[{w_lane, 3'b000} +: 8] = i_rbyte;
      o_wbyte                        = i_wdata[{w_lane, 3'b000} +: 8];
   end

endmodule

// File: rtl/mem_access_unit.sv
// Serialises 32-bit/8-bit loads and stores onto an 8-bit RAM, stalling the pipeline meanwhile.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned word requests without touching the RAM.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              R,
   input  logic              req_valid,
   input  logic              req_rw,
   input  logic              req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              err_misaligned,
   output logic              ram_en,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   state_t              r_state, w_state_nxt;
   logic                r_rw, r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata, r_rdata;
   logic [BEAT_W-1:0]   r_beat;
   logic                w_accept, w_last_beat, w_misaligned;
   logic [7:0]          w_wbyte;
   logic [31:0]         w_rword;

   // Gated by R so stall stays low while reset is held, even with a request pending.
   assign w_accept    = R && (r_state == IDLE) && req_valid;
   assign w_last_beat = r_size ? (r_beat == BEAT_W'(WORD_BEATS - 1))
                               : (r_beat == BEAT_W'(BYTE_BEATS - 1));

`ifdef MEM_ALIGN_CHECK_EN
   logic r_err;

   assign w_misaligned   = req_size && (req_addr[1:0] != 2'b00);
   assign err_misaligned = (r_state == DONE) && r_err;

   always_ff @(posedge clk or negedge R) begin
      if (!R)            r_err <= 1'b0;
      else if (w_accept) r_err <= w_misaligned;
   end
`else
   assign w_misaligned   = 1'b0;
   assign err_misaligned = 1'b0;
`endif

   mem_byte_lane u_lane (
      .i_size  (r_size),
      .i_beat  (r_beat),
      .i_wdata (r_wdata),
      .i_rbyte (ram_rdata),
      .i_rword (r_rdata),
      .o_wbyte (w_wbyte),
      .o_rword (w_rword)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge R) begin
      if (!R) r_state <= IDLE;
      else    r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         r_rw    <= 1'b0;
         r_size  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_beat  <= '0;
      end else if (w_accept) begin
         r_rw    <= req_rw;
         r_size  <= req_size;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_rdata <= '0;
         r_beat  <= '0;
      end else if (r_state == ACCESS) begin
         r_beat <= r_beat + 1'b1;
         if (!r_rw) r_rdata <= w_rword;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      rsp_valid   = 1'b0;
      rsp_rdata   = '0;
      ram_en      = 1'b0;
      ram_rw      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      case (r_state)
         IDLE: begin
            stall = w_accept;
            if (w_accept) w_state_nxt = w_misaligned ? DONE : ACCESS;
         end
         ACCESS: begin
            stall     = 1'b1;
            ram_en    = 1'b1;
            ram_rw    = r_rw;
            ram_addr  = r_addr + ADDR_W'(r_beat);
            ram_wdata = w_wbyte;
            if (w_last_beat) w_state_nxt = DONE;
         end
         DONE: begin
            rsp_valid   = 1'b1;
            rsp_rdata   = r_rdata;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests against a byte-wide RAM model.
module tb_mem_access_unit;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      int          stall;
   } rsp_t;

   typedef struct {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] wbyte;
   } beat_t;

   logic        clk = 1'b0;
   logic        R;
   logic        req_valid, req_rw, req_size;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        stall, rsp_valid, err_misaligned, ram_en, ram_rw;
   logic [31:0] rsp_rdata;
   logic [7:0]  ram_addr, ram_wdata, ram_rdata;

   logic [7:0]  mem [256];
   rsp_t        exp_q [$];
   beat_t       beat_q [$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          stall_cnt = 0;
   int          acc;
   rsp_t        mr;
   beat_t       mb;

   mem_access_unit #(.ADDR_W(8)) dut (
      .clk            (clk),
      .R              (R),
      .req_valid      (req_valid),
      .req_rw         (req_rw),
      .req_size       (req_size),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .stall          (stall),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .err_misaligned (err_misaligned),
      .ram_en         (ram_en),
      .ram_rw         (ram_rw),
      .ram_addr       (ram_addr),
      .ram_wdata      (ram_wdata),
      .ram_rdata      (ram_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign ram_rdata = mem[ram_addr];
   always @(posedge clk) if (ram_en && ram_rw) mem[ram_addr] <= ram_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares RAM beats and responses against the queued expectations.
   always @(negedge clk) begin
      if (!R) begin
         stall_cnt = 0;
      end else begin
         if (stall) stall_cnt++;
         if (ram_en) begin
            if (beat_q.size() == 0) check("beat_unexpected", 32'd1, 32'd0);
            else begin
               mb = beat_q.pop_front();
               check("ram_rw", 32'(ram_rw), 32'(mb.rw));
               check("ram_addr", 32'(ram_addr), 32'(mb.addr));
               if (mb.rw) check("ram_wdata", 32'(ram_wdata), 32'(mb.wbyte));
            end
         end else begin
            check("ram_wdata_idle", 32'(ram_wdata), 32'd0);
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
            else begin
               mr = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, mr.rdata);
               check("err_misaligned", 32'(err_misaligned), 32'(mr.err));
               check("rsp_cycle", 32'(cyc), 32'(mr.cyc));
               check("stall_cycles", 32'(stall_cnt), 32'(mr.stall));
            end
            stall_cnt = 0;
         end
      end
   end

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && (exp_q.size() > 0 || beat_q.size() > 0); i++) @(posedge clk);
      if (exp_q.size() > 0 || beat_q.size() > 0) begin
         check("drain_timeout", 32'(exp_q.size() + beat_q.size()), 32'd0);
         exp_q.delete();
         beat_q.delete();
      end
   endtask

   task automatic do_req(input logic rw, input logic size, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
      rsp_t  r;
      beat_t b;
      int    nb;
      logic  mis;
      mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = size && (addr[1:0] != 2'b00);
`endif
      @(posedge clk); #1;
      req_valid = 1'b1; req_rw = rw; req_size = size; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      acc = cyc;
      // Scramble the request inputs: they must be ignored once accepted.
      req_valid = 1'b0; req_rw = ~rw; req_size = ~size; req_addr = addr + 8'h55; req_wdata = ~wdata;
      nb = mis ? 0 : (size ? 4 : 1);
      for (int i = 0; i < nb; i++) begin
         b.rw    = rw;
         b.addr  = addr + 8'(i);
         b.wbyte = size ? wdata[31 - 8*i -: 8] : wdata[7:0];
         beat_q.push_back(b);
      end
      r.rdata = mis ? 32'd0 : exp_rdata;
      r.err   = mis;
      r.cyc   = acc + nb;
      r.stall = nb + 1;
      exp_q.push_back(r);
      wait_drain(20);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h34] = 8'h11; mem[8'h35] = 8'h22; mem[8'h36] = 8'h33; mem[8'h37] = 8'h44;
      mem[8'h38] = 8'hA5; mem[8'h39] = 8'h5A;
      mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34; mem[8'h00] = 8'h56; mem[8'h01] = 8'h78;
      mem[8'h51] = 8'h3C;
      for (int i = 8'h40; i < 8'h44; i++) mem[i] = 8'h77;

      // Reset with a request pending: all outputs must stay zero.
      R = 1'b0; req_valid = 1'b1; req_rw = 1'b1; req_size = 1'b1; req_addr = 8'h10; req_wdata = 32'hFFFF_FFFF;
      #12;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(err_misaligned), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_ram_rw", 32'(ram_rw), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      R = 1'b1;
      @(posedge clk); #1;
      check("idle_stall", 32'(stall), 32'd0);

      do_req(1'b0, 1'b1, 8'h34, 32'h0, 32'h1122_3344);        // word read
      do_req(1'b0, 1'b0, 8'h38, 32'h0, 32'h0000_00A5);        // byte read
      do_req(1'b1, 1'b1, 8'h3C, 32'hDEAD_BEEF, 32'h0);        // word write
      check("mem_3c", 32'(mem[8'h3C]), 32'hDE);
      check("mem_3d", 32'(mem[8'h3D]), 32'hAD);
      check("mem_3e", 32'(mem[8'h3E]), 32'hBE);
      check("mem_3f", 32'(mem[8'h3F]), 32'hEF);
      do_req(1'b0, 1'b1, 8'hFE, 32'h0, 32'h1234_5678);        // misaligned word, address wrap
      do_req(1'b1, 1'b0, 8'h50, 32'hFFFF_FF9C, 32'h0);        // byte write uses [7:0]
      check("mem_50", 32'(mem[8'h50]), 32'h9C);
      check("mem_51", 32'(mem[8'h51]), 32'h3C);
      do_req(1'b0, 1'b0, 8'h3D, 32'h0, 32'h0000_00AD);        // byte read of written data

      // Reset during beat 2 of a word write: only the first two bytes land.
      @(posedge clk); #1;
      req_valid = 1'b1; req_rw = 1'b1; req_size = 1'b1; req_addr = 8'h40; req_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      mb.rw = 1'b1; mb.addr = 8'h40; mb.wbyte = 8'hCA; beat_q.push_back(mb);
      mb.addr = 8'h41; mb.wbyte = 8'hFE; beat_q.push_back(mb);
      @(posedge clk); #1;
      @(posedge clk); #1;
      R = 1'b0;
      #1;
      check("abort_stall", 32'(stall), 32'd0);
      check("abort_ram_en", 32'(ram_en), 32'd0);
      check("abort_ram_addr", 32'(ram_addr), 32'd0);
      check("abort_ram_wdata", 32'(ram_wdata), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 R = 1'b1;
      repeat (4) @(posedge clk);
      check("abort_beats_left", 32'(beat_q.size()), 32'd0);
      check("mem_40", 32'(mem[8'h40]), 32'hCA);
      check("mem_41", 32'(mem[8'h41]), 32'hFE);
      check("mem_42", 32'(mem[8'h42]), 32'h77);
      check("mem_43", 32'(mem[8'h43]), 32'h77);
      do_req(1'b0, 1'b1, 8'h40, 32'h0, 32'hCAFE_7777);        // recovery after abort

      // Back-to-back byte reads with req_valid held high across DONE.
      @(posedge clk); #1;
      req_valid = 1'b1; req_rw = 1'b0; req_size = 1'b0; req_addr = 8'h38; req_wdata = 32'h0;
      @(posedge clk); #1;
      acc = cyc;
      req_addr = 8'h39;
      mb.rw = 1'b0; mb.addr = 8'h38; mb.wbyte = 8'h00; beat_q.push_back(mb);
      mb.addr = 8'h39; beat_q.push_back(mb);
      mr.rdata = 32'h0000_00A5; mr.err = 1'b0; mr.cyc = acc + 1; mr.stall = 2; exp_q.push_back(mr);
      mr.rdata = 32'h0000_005A; mr.cyc = acc + 4; exp_q.push_back(mr);
      @(posedge clk); #1;                                     // DONE: request not taken
      check("b2b_done_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;                                     // IDLE: second request taken
      check("b2b_idle_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_drain(20);
      repeat (3) @(posedge clk);
      check("final_rsp_queue", 32'(exp_q.size()), 32'd0);
      check("final_beat_queue", 32'(beat_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
